sc_datamem_io: RTL and testbench



---
 rtl/sc_io_pkg.sv | 22 ++
 rtl/sc_io_regs.sv | 113 +++++++++++
 rtl/sc_datamem_io.sv | 65 ++++++
 tb/tb_sc_datamem_io.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sc_io_pkg.sv
// Shared constants and helpers for the data-memory / memory-mapped I/O block.
package sc_io_pkg;

  // Word offsets inside the I/O window (addr[6:2]).
  localparam logic [4:0] OFF_OUT    = 5'd0;
  localparam logic [4:0] OFF_IN     = 5'd8;
  localparam logic [4:0] OFF_STATUS = 5'd16;
  localparam logic [4:0] OFF_MASK   = 5'd17;
  localparam logic [4:0] OFF_CYCLES = 5'd18;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sc_io_regs.sv
// I/O register window: output ports, synchronised inputs with sticky change
// flags, interrupt mask, free-running cycle counter and the I/O read mux.
module sc_io_regs
  import sc_io_pkg::*;
#(
  parameter int N_OUT = 3,
  parameter int N_IN  = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [4:0]            off,
  input  logic                  wr_en,
  input  logic [31:0]           datain,
  input  logic [3:0]            be,
  input  logic [32*N_IN-1:0]    in_port,
  output logic [31:0]           rdata,
  output logic [32*N_OUT-1:0]   out_port,
  output logic                  irq
);

  logic [32*N_OUT-1:0] out_q;
  logic [32*N_IN-1:0]  sync1_q;
  logic [32*N_IN-1:0]  sync2_q;
  logic [32*N_IN-1:0]  prev_q;
  logic [N_IN-1:0]     change;
  logic [N_IN-1:0]     w1c;
  logic [N_IN-1:0]     status_d;
  logic [N_IN-1:0]     status_q;
  logic [N_IN-1:0]     mask_q;
  logic [31:0]         cycles_q;

  // Output port registers, byte-lane writable.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (off == OFF_OUT + 5'(k)) begin
          out_q[32*k +: 32] <= be_merge(out_q[32*k +: 32], datain, be);
        end
      end
    end
  end

  // Two-flop synchroniser plus a history stage for change detection.
  // NOTE: non-blocking assignments make every stage capture its predecessor's
  // old value; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Sticky flag next state: clear first, then set, so a new change wins.
  always_comb begin
    change = '0;
    for (int k = 0; k < N_IN; k++) begin
      change[k] = (sync2_q[32*k +: 32] != prev_q[32*k +: 32]);
    end
    w1c      = (wr_en && off == OFF_STATUS && be[0]) ? datain[N_IN-1:0] : '0;
    status_d = (status_q & ~w1c) | change;
  end

  // Status flags and interrupt mask registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      status_q <= '0;
      mask_q   <= '0;
    end else begin
      status_q <= status_d;
      if (wr_en && off == OFF_MASK && be[0]) begin
        mask_q <= datain[N_IN-1:0];
      end
    end
  end

  // Cycle counter: a full-word write replaces that cycle's increment.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cycles_q <= '0;
    end else if (wr_en && off == OFF_CYCLES && be == 4'hF) begin
      cycles_q <= datain;
    end else begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  // I/O read mux; unmapped offsets read as zero.
  // NOTE: rdata gets its default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (off == OFF_OUT + 5'(k)) rdata = out_q[32*k +: 32];
    end
    for (int k = 0; k < N_IN; k++) begin
      if (off == OFF_IN + 5'(k)) rdata = sync2_q[32*k +: 32];
    end
    if (off == OFF_STATUS) rdata[N_IN-1:0] = status_q;
    if (off == OFF_MASK)   rdata[N_IN-1:0] = mask_q;
    if (off == OFF_CYCLES) rdata = cycles_q;
  end

  assign out_port = out_q;
  assign irq      = |(status_q & mask_q);

endmodule

// File: rtl/sc_datamem_io.sv
// Data memory plus memory-mapped I/O for the single-cycle CPU. addr[IO_BIT]
// selects between the word RAM and the I/O register window.
module sc_datamem_io
  import sc_io_pkg::*;
#(
  parameter int DMEM_WORDS = 32,
  parameter int N_OUT      = 3,
  parameter int N_IN       = 2,
  parameter int IO_BIT     = 7
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [31:0]           addr,
  input  logic [31:0]           datain,
  input  logic                  we,
  input  logic [3:0]            be,
  output logic [31:0]           dataout,
  output logic [32*N_OUT-1:0]   out_port,
  input  logic [32*N_IN-1:0]    in_port,
  output logic                  irq
);

  localparam int AW = $clog2(DMEM_WORDS);
  // Address bits that take part in decoding; the rest alias.
  localparam logic [31:0] ADDR_USED = (32'd1 << IO_BIT) | 32'h0000_007C |
                                      (((32'd1 << AW) - 32'd1) << 2);

  logic [31:0]   mem [DMEM_WORDS];
  logic [AW-1:0] idx;
  logic          is_io;
  logic [31:0]   io_rdata;
  logic          unused_addr;

  assign is_io       = addr[IO_BIT];
  assign idx         = addr[AW+1:2];
  assign unused_addr = ^(addr & ~ADDR_USED);

  // Word RAM with byte-lane stores.
  // NOTE: the RAM has no reset on purpose; its contents survive resetn and
  // a reset would prevent mapping it onto block memory.
  always_ff @(posedge clock) begin
    if (we && !is_io) begin
      mem[idx] <= be_merge(mem[idx], datain, be);
    end
  end

  sc_io_regs #(
    .N_OUT (N_OUT),
    .N_IN  (N_IN)
  ) u_io (
    .clock    (clock),
    .resetn   (resetn),
    .off      (addr[6:2]),
    .wr_en    (we && is_io),
    .datain   (datain),
    .be       (be),
    .in_port  (in_port),
    .rdata    (io_rdata),
    .out_port (out_port),
    .irq      (irq)
  );

  assign dataout = is_io ? io_rdata : mem[idx];

endmodule

// File: tb/tb_sc_datamem_io.sv
// Directed bench for sc_datamem_io. RAM is 16 words so the alias address
// 0x10 + 4*16 = 0x50 stays below the I/O select bit (bit 7).
module tb_sc_datamem_io;

  localparam int N_OUT = 3;
  localparam int N_IN  = 2;

  logic                clock;
  logic                resetn;
  logic [31:0]         addr;
  logic [31:0]         datain;
  logic                we;
  logic [3:0]          be;
  logic [31:0]         dataout;
  logic [32*N_OUT-1:0] out_port;
  logic [32*N_IN-1:0]  in_port;
  logic                irq;

  int n_vec = 0;
  int n_err = 0;

  sc_datamem_io #(
    .DMEM_WORDS (16),
    .N_OUT      (N_OUT),
    .N_IN       (N_IN),
    .IO_BIT     (7)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .addr     (addr),
    .datain   (datain),
    .we       (we),
    .be       (be),
    .dataout  (dataout),
    .out_port (out_port),
    .in_port  (in_port),
    .irq      (irq)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle store; returns 1 time unit after the capturing edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr   = a;
    datain = d;
    be     = b;
    we     = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0;
    be = 4'h0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dataout, exp);
  endtask

  initial begin
    addr    = '0;
    datain  = '0;
    we      = 1'b0;
    be      = 4'h0;
    in_port = '0;
    resetn  = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("rst_out0", out_port[31:0],  32'h0);
    check("rst_irq",  {31'd0, irq},    32'h0);
    #22 resetn = 1'b1;

    // Idle five edges after reset release.
    tick(5);
    load("cycles_after5", 32'h0000_00C8, 32'd5);
    check("idle_out0", out_port[31:0],  32'h0);
    check("idle_out1", out_port[63:32], 32'h0);
    check("idle_out2", out_port[95:64], 32'h0);
    check("idle_irq",  {31'd0, irq},    32'h0);
    load("idle_status", 32'h0000_00C0, 32'h0);
    load("idle_mask",   32'h0000_00C4, 32'h0);

    // RAM word store, byte store, alias read.
    store(32'h0000_0010, 32'h1234_5678, 4'hF);
    load("ram_sw", 32'h0000_0010, 32'h1234_5678);
    store(32'h0000_0010, 32'h0000_AB00, 4'b0010);
    load("ram_sb",    32'h0000_0010, 32'h1234_AB78);
    load("ram_alias", 32'h0000_0050, 32'h1234_AB78);

    // Output port write, byte-lane write, unmapped offset.
    store(32'h0000_0084, 32'hDEAD_BEEF, 4'hF);
    check("out1_sw",   out_port[63:32], 32'hDEAD_BEEF);
    check("out0_keep", out_port[31:0],  32'h0);
    load("out1_rd", 32'h0000_0084, 32'hDEAD_BEEF);
    store(32'h0000_0084, 32'h0000_0011, 4'b0001);
    load("out1_sb", 32'h0000_0084, 32'hDEAD_BE11);
    store(32'h0000_00F8, 32'hFFFF_FFFF, 4'hF);
    load("off30_rd", 32'h0000_00F8, 32'h0);
    check("off30_out0", out_port[31:0],  32'h0);
    check("off30_out1", out_port[63:32], 32'hDEAD_BE11);
    check("off30_out2", out_port[95:64], 32'h0);

    // Input synchroniser, sticky flag and interrupt.
    store(32'h0000_00C4, 32'h0000_0001, 4'hF);
    load("mask_rd", 32'h0000_00C4, 32'h1);
    in_port[0] = 1'b1;
    tick(1);
    load("in0_1edge", 32'h0000_00A0, 32'h0);
    tick(1);
    load("in0_2edge",     32'h0000_00A0, 32'h1);
    load("status_2edge",  32'h0000_00C0, 32'h0);
    check("irq_2edge", {31'd0, irq}, 32'h0);
    tick(1);
    load("status_3edge", 32'h0000_00C0, 32'h1);
    check("irq_3edge", {31'd0, irq}, 32'h1);

    // Second toggle: W1C lands on the same edge the flag is set again.
    in_port[0] = 1'b0;
    tick(2);
    store(32'h0000_00C0, 32'h0000_0001, 4'b0001);
    load("status_set_wins", 32'h0000_00C0, 32'h1);
    check("irq_set_wins", {31'd0, irq}, 32'h1);
    load("in0_back0", 32'h0000_00A0, 32'h0);
    store(32'h0000_00C0, 32'h0000_0001, 4'b0001);
    load("status_w1c", 32'h0000_00C0, 32'h0);
    check("irq_w1c", {31'd0, irq}, 32'h0);

    // Cycle counter load and wrap; partial write ignored.
    store(32'h0000_00C8, 32'hFFFF_FFFE, 4'hF);
    load("cyc_load", 32'h0000_00C8, 32'hFFFF_FFFE);
    tick(1);
    load("cyc_max", 32'h0000_00C8, 32'hFFFF_FFFF);
    tick(1);
    load("cyc_wrap", 32'h0000_00C8, 32'h0);
    store(32'h0000_00C8, 32'h0000_1234, 4'b0011);
    load("cyc_sh_ignored", 32'h0000_00C8, 32'h1);

    // Build up state, then reset asynchronously in the middle of a store.
    store(32'h0000_0004, 32'hCAFE_F00D, 4'hF);
    store(32'h0000_0080, 32'h0000_0055, 4'hF);
    check("out0_pre", out_port[31:0], 32'h55);
    store(32'h0000_00C4, 32'h0000_0003, 4'hF);
    in_port[32] = 1'b1;
    tick(3);
    check("irq_pre", {31'd0, irq}, 32'h1);
    load("status_pre", 32'h0000_00C0, 32'h2);
    addr   = 32'h0000_0080;
    datain = 32'h0000_0077;
    be     = 4'hF;
    we     = 1'b1;
    #3 resetn = 1'b0;
    #1;
    check("rst_mid_out0", out_port[31:0],  32'h0);
    check("rst_mid_out1", out_port[63:32], 32'h0);
    check("rst_mid_irq",  {31'd0, irq},    32'h0);
    we = 1'b0;
    be = 4'h0;
    load("rst_mid_cycles", 32'h0000_00C8, 32'h0);
    load("rst_mid_mask",   32'h0000_00C4, 32'h0);
    load("rst_mid_status", 32'h0000_00C0, 32'h0);
    load("rst_ram_w1",     32'h0000_0004, 32'hCAFE_F00D);
    load("rst_ram_w4",     32'h0000_0010, 32'h1234_AB78);
    #1 resetn = 1'b1;
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
